debug_trace_tx: RTL and testbench
=================================

DEBUG_TRACE_TX -- requirements
Module: debug_trace_tx

Purpose: captures a CPU register snapshot on request and streams it to a host as a framed UART byte stream. It is the transmitting end of the register-monitoring interface.

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 4, giving the clk cycles per UART bit; legal values are 2..65535.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- snap_req  in  1  one-cycle snapshot request.
- regA, regF, regB, regC, regD, regE, regH, regL  in  8 each  CPU register values.
- PC  in  16  CPU program counter.
- SP  in  16  CPU stack pointer.
- IR  in  8  CPU instruction register.
- tx  out  1  UART serial line; idles high.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.
- dropped  out  1  one-cycle pulse when a request is rejected.
- frame_count  out  16  number of completed frames.
REQ-003 The clock SHALL be clk, and reset SHALL be rst, synchronous and active-high; there SHALL be no other clock or asynchronous input.

Function
REQ-004 Frame format: 15 bytes, each sent UART 8N1, LSB first.
- Byte 0: sync 0xA5.
- Bytes 1..8: A, F, B, C, D, E, H, L.
- Bytes 9..10: PC[15:8], PC[7:0].
- Bytes 11..12: SP[15:8], SP[7:0].
- Byte 13: IR.
- Byte 14: checksum.
REQ-005 The checksum SHALL be the sum of bytes 1..13 modulo 256; the sync byte is excluded.
REQ-006 State machine: IDLE -> START -> DATA -> STOP.
- STOP -> START while the byte index is below 14.
- STOP -> IDLE after byte 14.
REQ-007 Bit timing:
- START drives tx=0 for CLKS_PER_BIT cycles.
- DATA drives 8 bits, CLKS_PER_BIT cycles each.
- STOP drives tx=1 for CLKS_PER_BIT cycles.
REQ-008 Consecutive bytes SHALL be back-to-back, with no idle bit between a stop bit and the next start bit.
REQ-009 Capture: snap_req sampled high in IDLE SHALL latch all register inputs in that same edge; later input changes SHALL NOT affect the frame.
REQ-010 Latency: tx SHALL go low on the cycle after an accepted snap_req, and busy SHALL rise on that same cycle.
REQ-011 Total frame length SHALL be exactly 150*CLKS_PER_BIT cycles of busy=1.
REQ-012 On the cycle after the last stop-bit cycle:
- busy=0 and frame_done=1 for exactly one cycle;
- frame_count increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-013 A snap_req in the frame_done cycle SHALL be accepted, since the block is then in IDLE.
REQ-014 snap_req while busy=1 SHALL be ignored and SHALL pulse dropped for one cycle, on the cycle after the sample; the frame in progress SHALL be unaffected.
REQ-015 The checksum SHALL be computed from the latched snapshot; it SHALL NOT be affected by mid-frame input changes.
REQ-016 The bit counter SHALL count 0..7, the byte index 0..14, and the baud counter 0..CLKS_PER_BIT-1; none SHALL exceed its range.

Reset
REQ-017 rst=1 at a clock edge SHALL force the following on the next cycle:
- state IDLE, tx=1;
- busy, frame_done, dropped all 0;
- frame_count 0x0000;
- all counters and the latched snapshot cleared to 0.
REQ-018 Reset mid-frame SHALL abort the frame immediately, leaving tx=1 with no partial stop bit.
- The aborted frame SHALL NOT count and SHALL NOT pulse frame_done.
REQ-019 snap_req asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-020 Post-boot snapshot, with CLKS_PER_BIT=4:
- Stimulus: A=01 F=B0 B=00 C=13 D=00 E=D8 H=01 L=4D PC=0100 SP=FFFE IR=00.
- Response: decoded bytes A5 01 B0 00 13 00 D8 01 4D 01 00 FF FE 00 E8; busy high 600 cycles; frame_done at cycle 601 after the request; frame_count=1.
REQ-021 Bit timing:
- Stimulus: byte 0xA5 with CLKS_PER_BIT=4.
- Response: tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
REQ-022 Request while busy:
- Stimulus: snap_req at cycle 100 of a frame, with regA changed to 0xFF.
- Response: dropped pulses once; the frame still carries the original A; frame_count=1.
REQ-023 Back-to-back frames:
- Stimulus: snap_req in the frame_done cycle.
- Response: tx low on the next cycle; second frame correct; frame_count=2.
REQ-024 Reset mid-frame:
- Stimulus: rst at cycle 300.
- Response: tx=1, busy=0, frame_count=0, no frame_done; a new snap_req then yields a full correct frame.
REQ-025 Counter wrap:
- Stimulus: force frame_count=0xFFFF, then complete one frame.
- Response: frame_count=0x0000 and frame_done pulses once.

Source files
------------

// File: rtl/debug_trace_tx.sv
// Register-snapshot trace transmitter: latches CPU state on request and streams
// a 15-byte frame (sync, 13 data bytes, checksum) as back-to-back UART 8N1 bytes.
module debug_trace_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snap_req,
    input  logic [7:0]  regA,
    input  logic [7:0]  regF,
    input  logic [7:0]  regB,
    input  logic [7:0]  regC,
    input  logic [7:0]  regD,
    input  logic [7:0]  regE,
    input  logic [7:0]  regH,
    input  logic [7:0]  regL,
    input  logic [15:0] PC,
    input  logic [15:0] SP,
    input  logic [7:0]  IR,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        dropped,
    output logic [15:0] frame_count
);

    localparam int         NUM_DATA  = 13;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [3:0]  r_byte;
    logic [3:0]  w_byte_next;
    logic        r_frame_done;
    logic        w_done_next;
    logic        r_dropped;
    logic        w_dropped_next;
    logic        w_capture;
    logic [15:0] r_frame_count;

    logic [7:0]  r_snap [0:NUM_DATA-1];
    logic [7:0]  w_in   [0:NUM_DATA-1];
    logic [7:0]  w_frame [0:14];
    logic [7:0]  w_csum;
    logic [7:0]  w_cur_byte;
    logic        w_baud_last;
    logic        w_tx;

    assign w_in[0]  = regA;
    assign w_in[1]  = regF;
    assign w_in[2]  = regB;
    assign w_in[3]  = regC;
    assign w_in[4]  = regD;
    assign w_in[5]  = regE;
    assign w_in[6]  = regH;
    assign w_in[7]  = regL;
    assign w_in[8]  = PC[15:8];
    assign w_in[9]  = PC[7:0];
    assign w_in[10] = SP[15:8];
    assign w_in[11] = SP[7:0];
    assign w_in[12] = IR;

    // Checksum derives only from the latched copy, so input changes mid-frame cannot reach it.
    always_comb begin
        w_csum = 8'h00;
        for (int i = 0; i < NUM_DATA; i++) begin
            w_csum = w_csum + r_snap[i];
        end
    end

    assign w_frame[0]  = SYNC_BYTE;
    assign w_frame[14] = w_csum;
    generate
        for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_frame
            assign w_frame[gi + 1] = r_snap[gi];
        end
    endgenerate

    assign w_cur_byte  = w_frame[r_byte];
    assign w_baud_last = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_next     = r_bit;
        w_byte_next    = r_byte;
        w_done_next    = 1'b0;
        w_capture      = 1'b0;
        w_dropped_next = snap_req && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (snap_req) begin
                    w_state_next = S_START;
                    w_baud_next  = 16'd0;
                    w_bit_next   = 3'd0;
                    w_byte_next  = 4'd0;
                    w_capture    = 1'b1;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_next  = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_next = 16'd0;
                    if (r_bit == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_next = 16'd0;
                    if (r_byte == 4'd14) begin
                        w_byte_next  = 4'd0;
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_byte_next  = r_byte + 4'd1;
                        w_state_next = S_START;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_baud        <= 16'd0;
            r_bit         <= 3'd0;
            r_byte        <= 4'd0;
            r_frame_done  <= 1'b0;
            r_dropped     <= 1'b0;
            r_frame_count <= 16'd0;
            for (int i = 0; i < NUM_DATA; i++) begin
                r_snap[i] <= 8'h00;
            end
        end else begin
            r_state      <= w_state_next;
            r_baud       <= w_baud_next;
            r_bit        <= w_bit_next;
            r_byte       <= w_byte_next;
            r_frame_done <= w_done_next;
            r_dropped    <= w_dropped_next;
            if (w_done_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_capture) begin
                for (int i = 0; i < NUM_DATA; i++) begin
                    r_snap[i] <= w_in[i];
                end
            end
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = w_cur_byte[r_bit];
            default: w_tx = 1'b1;
        endcase
    end

    assign tx          = w_tx;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign dropped     = r_dropped;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_debug_trace_tx.sv
// Self-checking bench for debug_trace_tx: expected frames come from a byte-level
// model of the frame format, decoded from tx and compared bit-period by bit-period.
module tb_debug_trace_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 150 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        snap_req;
    logic [7:0]  regA, regF, regB, regC, regD, regE, regH, regL, IR;
    logic [15:0] PC, SP;
    logic        tx, busy, frame_done, dropped;
    logic [15:0] frame_count;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [7:0]  exp_bytes [15];
    logic [15:0] exp_count = 16'd0;

    debug_trace_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .snap_req(snap_req),
        .regA(regA), .regF(regF), .regB(regB), .regC(regC),
        .regD(regD), .regE(regE), .regH(regH), .regL(regL),
        .PC(PC), .SP(SP), .IR(IR),
        .tx(tx), .busy(busy), .frame_done(frame_done),
        .dropped(dropped), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_regs_random();
        regA = 8'($urandom); regF = 8'($urandom); regB = 8'($urandom); regC = 8'($urandom);
        regD = 8'($urandom); regE = 8'($urandom); regH = 8'($urandom); regL = 8'($urandom);
        PC = 16'($urandom); SP = 16'($urandom); IR = 8'($urandom);
    endtask

    // Frame model: sync, the registers in wire order, then sum of data bytes mod 256.
    task automatic start_req();
        int sum;
        exp_bytes[0]  = 8'hA5;
        exp_bytes[1]  = regA; exp_bytes[2] = regF; exp_bytes[3] = regB; exp_bytes[4] = regC;
        exp_bytes[5]  = regD; exp_bytes[6] = regE; exp_bytes[7] = regH; exp_bytes[8] = regL;
        exp_bytes[9]  = PC[15:8]; exp_bytes[10] = PC[7:0];
        exp_bytes[11] = SP[15:8]; exp_bytes[12] = SP[7:0];
        exp_bytes[13] = IR;
        sum = 0;
        for (int k = 1; k <= 13; k++) sum += int'(exp_bytes[k]);
        exp_bytes[14] = 8'(sum % 256);
        snap_req = 1'b1;
    endtask

    // Entered at the negedge where snap_req was raised; samples every negedge of the frame.
    task automatic run_frame(input int drop_at, input bit chain);
        logic [7:0] act [15];
        int   shape_err, busy_err, drops, drop_seen, bitpos, bi, b;
        logic exp_tx;
        shape_err = 0; busy_err = 0; drops = 0; drop_seen = -1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            bitpos = c / CPB; bi = bitpos / 10; b = bitpos % 10;
            if (b == 0)      exp_tx = 1'b0;
            else if (b == 9) exp_tx = 1'b1;
            else             exp_tx = exp_bytes[bi][b-1];
            if (tx !== exp_tx) shape_err++;
            if (busy !== 1'b1 || frame_done !== 1'b0) busy_err++;
            if (dropped === 1'b1) begin
                drops++;
                drop_seen = c;
            end
            if (b >= 1 && b <= 8 && (c % CPB) == CPB / 2) act[bi][b-1] = tx;
            set_regs_random();
            snap_req = (c == drop_at);
            if (c == drop_at) regA = 8'hFF;
            @(negedge clk);
        end
        exp_count = exp_count + 16'd1;
        chk("end_busy", busy, 0);
        chk("end_frame_done", frame_done, 1);
        chk("end_frame_count", frame_count, exp_count);
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("byte%0d", k), act[k], exp_bytes[k]);
            $display("  byte %0d: got %02h want %02h", k, act[k], exp_bytes[k]);
        end
        chk("tx_bit_timing_errors", shape_err, 0);
        chk("busy_window_errors", busy_err, 0);
        chk("dropped_pulses", drops, (drop_at >= 0) ? 1 : 0);
        chk("dropped_cycle", drop_seen, (drop_at >= 0) ? drop_at + 1 : -1);
        if (chain) begin
            set_regs_random();
            start_req();
        end else begin
            @(negedge clk);
            chk("done_is_one_cycle", frame_done, 0);
        end
    endtask

    initial begin
        int quiet_err;
        rst = 1'b1; snap_req = 1'b0;
        set_regs_random();
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_frame_count", frame_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Post-boot snapshot with known values.
        regA = 8'h01; regF = 8'hB0; regB = 8'h00; regC = 8'h13;
        regD = 8'h00; regE = 8'hD8; regH = 8'h01; regL = 8'h4D;
        PC = 16'h0100; SP = 16'hFFFE; IR = 8'h00;
        start_req();
        run_frame(-1, 1'b0);

        // Request while busy at cycle 100, with regA changed.
        set_regs_random();
        start_req();
        run_frame(100, 1'b0);

        // Back-to-back: second request in the frame_done cycle.
        set_regs_random();
        start_req();
        run_frame(-1, 1'b1);
        run_frame(-1, 1'b0);

        // Reset mid-frame, with a simultaneous snap_req that must be ignored.
        set_regs_random();
        start_req();
        @(negedge clk);
        snap_req = 1'b0;
        repeat (299) @(negedge clk);
        rst = 1'b1; snap_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; snap_req = 1'b0;
        exp_count = 16'd0;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_frame_count", frame_count, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_dropped", dropped, 0);
        quiet_err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) quiet_err++;
        end
        chk("abort_stays_idle", quiet_err, 0);

        set_regs_random();
        start_req();
        run_frame(-1, 1'b0);

        // Counter wrap from 0xFFFF.
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        exp_count = 16'hFFFF;
        set_regs_random();
        start_req();
        run_frame(-1, 1'b0);

        // A couple more randomized frames, one with a late drop.
        set_regs_random();
        start_req();
        run_frame(int'($urandom_range(0, FRAME - 2)), 1'b0);
        set_regs_random();
        start_req();
        run_frame(-1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
